// File: rtl/booth_mult8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_mult8 : sequential signed radix-2 Booth multiplier on an add/sub stage |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module arith #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ov_o
);

  always_comb begin
    sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);
    // Signed overflow: operands effectively share a sign but the result does not.
    if (sub_i) begin
      ov_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      ov_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end
  end

endmodule

module booth_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_LAST_ITER = 3'd7;

  state_t               state_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     m_q;
  logic                 q1_q;
  logic [2:0]           cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     w_sum;
  logic                 w_ov;
  logic                 w_sub;
  logic                 w_op_en;
  logic [WIDTH-1:0]     w_new_acc;
  logic                 w_sign;
  logic [WIDTH-1:0]     acc_d;
  logic [WIDTH-1:0]     q_d;
  logic                 q1_d;

  arith #(.WIDTH(WIDTH)) u_arith (
    .a_i   (acc_q),
    .b_i   (m_q),
    .sub_i (w_sub),
    .sum_o (w_sum),
    .ov_o  (w_ov)
  );

  always_comb begin
    w_sub   = (q_q[0] == 1'b1) && (q1_q == 1'b0);
    w_op_en = q_q[0] ^ q1_q;
    // The true sign of acc +/- M is SUM's MSB flipped whenever the 8-bit add overflowed.
    if (w_op_en) begin
      w_new_acc = w_sum;
      w_sign    = w_sum[WIDTH-1] ^ w_ov;
    end else begin
      w_new_acc = acc_q;
      w_sign    = acc_q[WIDTH-1];
    end
    acc_d = {w_sign, w_new_acc[WIDTH-1:1]};
    q_d   = {w_new_acc[0], q_q[WIDTH-1:1]};
    q1_d  = q_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= mcand;
            q_q     <= mplier;
            acc_q   <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == c_LAST_ITER) begin
            product_q <= {acc_d, q_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire
